// File: rtl/timer.sv
// Completion timer for the dynamic ripple-carry adder: counts cycles after the
// operand launch strobe and raises R once the carry chain has settled.
module timer #(
    parameter int HALF_CYCLES    = 4,
    parameter int THREE_Q_CYCLES = 6,
    parameter int FULL_CYCLES    = 8,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] middle_p,
    input  logic       F,
    output logic       R
);

    localparam logic [CNT_W-1:0] LIM_HALF  = CNT_W'(HALF_CYCLES);
    localparam logic [CNT_W-1:0] LIM_THREE = CNT_W'(THREE_Q_CYCLES);
    localparam logic [CNT_W-1:0] LIM_FULL  = CNT_W'(FULL_CYCLES);

    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] limit_reg, limit_next;
    logic             armed_reg, armed_next;
    logic             done_reg, done_next;
    logic [CNT_W-1:0] limit_sel;
    logic [CNT_W:0]   count_inc;

    // Longest possible carry chain is bounded by how far the middle
    // propagate run extends.
    always_comb begin
        limit_sel = LIM_HALF;
        if (middle_p == 4'b1111) begin
            limit_sel = LIM_FULL;
        end else if (middle_p[2:1] == 2'b11) begin
            limit_sel = LIM_THREE;
        end
    end

    // One extra bit so the compare cannot be fooled by wrap-around.
    assign count_inc = {1'b0, count_reg} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        count_next = count_reg;
        limit_next = limit_reg;
        armed_next = armed_reg;
        done_next  = done_reg;
        if (F) begin
            count_next = '0;
            limit_next = limit_sel;
            armed_next = 1'b1;
            done_next  = 1'b0;
        end else if (armed_reg && !done_reg) begin
            count_next = count_inc[CNT_W-1:0];
            if (count_inc >= {1'b0, limit_reg}) begin
                done_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            limit_reg <= LIM_FULL;
            armed_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            limit_reg <= limit_next;
            armed_reg <= armed_next;
            done_reg  <= done_next;
        end
    end

    // F drops R immediately so the output buffer closes before the new operands ripple.
    assign R = done_reg & ~F;

endmodule

// File: tb/tb_timer.sv
// Directed self-checking bench for the adder completion timer.
module tb_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] middle_p;
    logic       F;
    logic       R;

    int vectors     = 0;
    int miscompares = 0;

    timer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .middle_p (middle_p),
        .F        (F),
        .R        (R)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed R=%b expected R=%b", tag, obs, exp);
        end
    endtask

    // Pulse F for one edge with the given propagate bits, then release.
    task automatic launch(input logic [3:0] mp);
        middle_p = mp;
        F = 1'b1;
        tick();
        F = 1'b0;
    endtask

    // R must stay low for lim-1 F-low edges and rise on edge lim.
    task automatic expect_ready(input int lim, input string tag);
        chk({tag, "_pre"}, R, 1'b0);
        for (int i = 1; i <= lim; i++) begin
            tick();
            $display("%s edge %0d R=%b", tag, i, R);
            chk(tag, R, (i >= lim) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        F        = 1'b0;
        middle_p = 4'b0000;
        tick();
        tick();
        chk("reset_R", R, 1'b0);
        rst_n = 1'b1;

        // Idle after reset: nothing armed, R stays low.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", R, 1'b0);
        end
        $display("idle 20 cycles done R=%b", R);

        // Full worst-case wait, then sticky R.
        launch(4'b1111);
        expect_ready(8, "full");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("full_sticky", R, 1'b1);
        end

        // Three-quarter and half waits; middle_p changes while F=0 are ignored.
        launch(4'b0110);
        expect_ready(6, "three_q");
        launch(4'b1011);
        middle_p = 4'b1111;
        expect_ready(4, "half_ignore_mp");

        // F high drops R before any edge; long F hold then half wait.
        middle_p = 4'b0000;
        F = 1'b1;
        #1;
        chk("f_comb_drop", R, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f_hold", R, 1'b0);
        end
        F = 1'b0;
        expect_ready(4, "half_after_hold");

        // Abort a full wait mid-count; the new limit comes from the restart.
        launch(4'b1111);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_pre", R, 1'b0);
        end
        launch(4'b0001);
        expect_ready(4, "restart_half");

        // Asynchronous reset between edges while R is high.
        chk("pre_reset_R", R, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_R", R, 1'b0);
        tick();
        chk("reset_hold_R", R, 1'b0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_reset_idle", R, 1'b0);
        end

        // Normal operation resumes after reset.
        launch(4'b1110);
        expect_ready(6, "post_reset_three_q");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
